// File: rtl/fuec_13_8_pkg.sv
// FUEC (13,8) shared definitions.
// Codeword layout: cw[7:0] = data, cw[12:8] = parity.
// The parity-check matrix gives 25 distinct non-zero syndromes:
// every single-bit error and every adjacent double-bit error.
// Any other non-zero syndrome is reported as uncorrectable.
package fuec_13_8_pkg;

  localparam int CW_W   = 13;
  localparam int DATA_W = 8;
  localparam int PAR_W  = 5;

  typedef enum logic [2:0] {
    IDLE, RD, WT, CK, WR
`ifdef FUEC_SCRUB_RECHECK_EN
    , RRD, RWT, RCK
`endif
  } scrub_state_t;

  // Parity-check column for codeword bit i. Parity bits use unit columns,
  // which keeps the encoder systematic.
  function automatic logic [PAR_W-1:0] h_col(input int i);
    case (i)
      0:       h_col = 5'd14;
      1:       h_col = 5'd19;
      2:       h_col = 5'd9;
      3:       h_col = 5'd18;
      4:       h_col = 5'd5;
      5:       h_col = 5'd17;
      6:       h_col = 5'd13;
      7:       h_col = 5'd10;
      8:       h_col = 5'd1;
      9:       h_col = 5'd2;
      10:      h_col = 5'd4;
      11:      h_col = 5'd8;
      12:      h_col = 5'd16;
      default: h_col = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/fuec_decoder_13_8.sv
// FUEC (13,8) decoder: syndrome lookup over single and adjacent-pair errors.
//   r             : received codeword
//   r_fix         : r with the located error pattern flipped back
//   no_error      : syndrome is zero
//   corrected     : syndrome matched a correctable pattern
//   uncorrectable : non-zero syndrome with no match (r_fix = r)
module fuec_decoder_13_8
  import fuec_13_8_pkg::*;
(
  input  logic [CW_W-1:0] r,
  output logic [CW_W-1:0] r_fix,
  output logic            no_error,
  output logic            corrected,
  output logic            uncorrectable
);

  logic [PAR_W-1:0] syn;
  logic [CW_W-1:0]  err;

  always_comb begin
    syn = '0;
    for (int i = 0; i < CW_W; i++)
      if (r[i]) syn ^= h_col(i);
    err = '0;
    for (int i = 0; i < CW_W; i++)
      if (syn == h_col(i)) err = CW_W'(1) << i;
    for (int i = 0; i < CW_W - 1; i++)
      if (syn == (h_col(i) ^ h_col(i + 1))) err = CW_W'(3) << i;
    no_error      = (syn == '0);
    corrected     = !no_error && (err != '0);
    uncorrectable = !no_error && (err == '0);
    r_fix         = r ^ err;
  end

endmodule

// File: rtl/fuec_encoder_13_8.sv
// FUEC (13,8) systematic encoder.
//   data : 8-bit payload
//   cw   : 13-bit codeword {parity, data}
module fuec_encoder_13_8
  import fuec_13_8_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw
);

  logic [PAR_W-1:0] par;

  always_comb begin
    par = '0;
    for (int i = 0; i < DATA_W; i++)
      if (data[i]) par ^= h_col(i);
    cw = {par, data};
  end

endmodule

// File: rtl/fuec_scrubber_13_8.sv
// Background scrubber for FUEC (13,8) protected memory.
// On start, every address is read, decoded, and correctable words are written
// back repaired. Uncorrectable words are logged (unc_addr, unc_irq, unc_cnt)
// and never written.
// Optional macro FUEC_SCRUB_RECHECK_EN: after each write-back the address is
// re-read and anything other than a clean word is logged as uncorrectable.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start / busy / done           pass control and status
//   mem_req/we/addr/wdata, mem_gnt, mem_rdata
//                                 shared single-port memory; rdata one
//                                 cycle after an accepted read
//   corr_cnt, unc_cnt             saturating per-pass counters
//   unc_addr, unc_irq             last uncorrectable address, pulse per word
module fuec_scrubber_13_8
  import fuec_13_8_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  unc_cnt,
  output logic [ADDR_W-1:0] unc_addr,
  output logic              unc_irq
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  scrub_state_t      state, state_d;
  logic [ADDR_W-1:0] addr;
  logic [CW_W-1:0]   r_q, wdata_q, fix;
  logic              dec_ok, dec_corr, dec_unc;
  logic              adv, cap, fix_ld, inc_corr, inc_unc, clr;

  fuec_decoder_13_8 u_dec (
    .r             (r_q),
    .r_fix         (fix),
    .no_error      (dec_ok),
    .corrected     (dec_corr),
    .uncorrectable (dec_unc)
  );

  always_comb begin
    state_d  = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    adv      = 1'b0;
    cap      = 1'b0;
    fix_ld   = 1'b0;
    inc_corr = 1'b0;
    inc_unc  = 1'b0;
    clr      = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr     = 1'b1;
        state_d = RD;
      end
      RD: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = WT;
      end
      WT: begin
        cap     = 1'b1;
        state_d = CK;
      end
      CK: begin
        // decoder flags are one-hot
        if (dec_ok) adv = 1'b1;
        if (dec_unc) begin
          inc_unc = 1'b1;
          adv     = 1'b1;
        end
        if (dec_corr) begin
          fix_ld   = 1'b1;
          inc_corr = 1'b1;
          state_d  = WR;
        end
      end
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
`ifdef FUEC_SCRUB_RECHECK_EN
        if (mem_gnt) state_d = RRD;
`else
        if (mem_gnt) adv = 1'b1;
`endif
      end
`ifdef FUEC_SCRUB_RECHECK_EN
      RRD: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = RWT;
      end
      RWT: begin
        cap     = 1'b1;
        state_d = RCK;
      end
      RCK: begin
        // a just-repaired word must now read back clean
        inc_unc = !dec_ok;
        adv     = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (adv) state_d = (addr == LAST) ? IDLE : RD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      r_q      <= '0;
      wdata_q  <= '0;
      corr_cnt <= '0;
      unc_cnt  <= '0;
      unc_addr <= '0;
      unc_irq  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_d;
      unc_irq <= inc_unc;
      done    <= adv && (addr == LAST);
      if (clr) begin
        addr     <= '0;
        corr_cnt <= '0;
        unc_cnt  <= '0;
      end else if (adv && addr != LAST) begin
        addr <= addr + ADDR_W'(1);
      end
      if (cap)    r_q     <= mem_rdata;
      if (fix_ld) wdata_q <= fix;
      if (inc_corr && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      if (inc_unc) begin
        unc_addr <= addr;
        if (unc_cnt != '1) unc_cnt <= unc_cnt + CNT_W'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = addr;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_fuec_scrubber_13_8.sv
// Scoreboard bench for fuec_scrubber_13_8 (DEPTH=4, CNT_W=2 so saturation is
// reachable). A reference model decodes each word by searching the full
// codebook for a codeword within one correctable error pattern and pushes
// expected writes, irq addresses and done records; a forked monitor pops and
// compares whenever the DUT presents them.
module tb_fuec_scrubber_13_8;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, load = 1'b0;
  logic busy, done, mem_req, mem_we, mem_gnt, unc_irq;
  logic [AW-1:0] mem_addr, unc_addr;
  logic [12:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0] corr_cnt, unc_cnt;
  logic [7:0]  enc_d;
  logic [12:0] enc_cw;

  always #5 clk = ~clk;

  fuec_scrubber_13_8 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .corr_cnt(corr_cnt), .unc_cnt(unc_cnt), .unc_addr(unc_addr),
    .unc_irq(unc_irq)
  );

  fuec_encoder_13_8 u_enc (.data(enc_d), .cw(enc_cw));

  typedef struct { int cyc; int corr; int unc; int uaddr; } done_t;
  typedef struct { int addr; int data; } wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];
  int    irq_q[$];

  logic [12:0] cb[256];
  logic [12:0] img[DEPTH], mem[DEPTH], exp_mem[DEPTH];
  int stalls[64];
  int stall_left = 0, req_idx = 0, pcnt = 0, start_cyc = 0, unc_last = 0;
  int n_cmp = 0, n_fail = 0;

  always @(posedge clk) pcnt <= pcnt + 1;

  // behavioural memory: 1-cycle read, per-request grant delays from stalls[]
  assign mem_gnt = (stall_left == 0);
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= img[a];
      req_idx    <= 0;
      stall_left <= stalls[0];
    end else if (mem_req) begin
      if (stall_left > 0) stall_left <= stall_left - 1;
      else begin
        req_idx    <= req_idx + 1;
        stall_left <= stalls[(req_idx + 1) % 64];
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end
    end
    if (mem_req && mem_gnt && !mem_we) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 13'($urandom);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic unexpected(input string name, input int v);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0d", name, v);
  endtask

  // 0 clean, 1 correctable (fix = nearest codeword), 2 uncorrectable
  function automatic void classify(input logic [12:0] r, output int kind,
                                   output logic [12:0] fix);
    logic [12:0] e;
    int n;
    kind = 2;
    fix  = r;
    for (int d = 0; d < 256; d++) begin
      e = r ^ cb[d];
      n = $countones(e);
      if (n == 0) begin kind = 0; fix = cb[d]; end
      else if (n == 1 || (n == 2 && (e & (e >> 1)) != 0)) begin
        kind = 1;
        fix  = cb[d];
      end
    end
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_pass();
    int cost = 0, nreq = 0, corr = 0, unc = 0, st = 0, kind;
    logic [12:0] fix;
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[a] = img[a];
      classify(img[a], kind, fix);
      if (kind == 1) begin
        cost += 4; nreq += 2; corr++;
`ifdef FUEC_SCRUB_RECHECK_EN
        cost += 3; nreq += 1;
`endif
        wr_q.push_back('{a, int'(fix)});
        exp_mem[a] = fix;
      end else begin
        cost += 3; nreq += 1;
        if (kind == 2) begin
          unc++;
          unc_last = a;
          irq_q.push_back(a);
        end
      end
    end
    for (int i = 0; i < nreq; i++) st += stalls[i];
    done_q.push_back('{1 + cost + st, sat(corr), sat(unc), unc_last});
  endtask

  task automatic monitor();
    logic p_stall = 1'b0, p_we = 1'b0;
    int p_addr = 0, p_wdata = 0;
    done_t d;
    wr_t w;
    forever begin
      @(negedge clk);
      if (p_stall) begin
        chk("stall_req", int'(mem_req), 1);
        chk("stall_addr", int'(mem_addr), p_addr);
        chk("stall_we", int'(mem_we), int'(p_we));
        chk("stall_wdata", int'(mem_wdata), p_wdata);
      end
      p_stall = mem_req && !mem_gnt && !rst;
      p_addr  = int'(mem_addr);
      p_we    = mem_we;
      p_wdata = int'(mem_wdata);
      if (mem_req && mem_we && mem_gnt) begin
        if (wr_q.size() == 0) unexpected("write", int'(mem_addr));
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", int'(mem_addr), w.addr);
          chk("wr_data", int'(mem_wdata), w.data);
        end
      end
      if (unc_irq) begin
        if (irq_q.size() == 0) unexpected("unc_irq", int'(unc_addr));
        else chk("irq_addr", int'(unc_addr), irq_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done", pcnt - start_cyc);
        else begin
          d = done_q.pop_front();
          chk("done_cycle", pcnt - start_cyc, d.cyc);
          chk("corr_cnt", int'(corr_cnt), d.corr);
          chk("unc_cnt", int'(unc_cnt), d.unc);
          chk("unc_addr", int'(unc_addr), d.uaddr);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_req"}, int'(mem_req), 0);
    chk({tag, "_we"}, int'(mem_we), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_corr"}, int'(corr_cnt), 0);
    chk({tag, "_unc"}, int'(unc_cnt), 0);
    chk({tag, "_uaddr"}, int'(unc_addr), 0);
    chk({tag, "_irq"}, int'(unc_irq), 0);
  endtask

  task automatic load_and_start();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    start = 1'b1;
    start_cyc = pcnt;
  endtask

  // spur > 0: pulse start at that cycle of the pass (must be ignored)
  task automatic run_pass(input int spur);
    model_pass();
    load_and_start();
    for (int k = 0; k < 600 && done_q.size() != 0; k++) begin
      @(posedge clk); #1;
      start = (spur > 0 && pcnt - start_cyc == spur);
    end
    start = 1'b0;
    chk("done_seen", done_q.size(), 0);
    done_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("writes_left", wr_q.size(), 0);
    chk("irqs_left", irq_q.size(), 0);
    wr_q.delete();
    irq_q.delete();
    for (int a = 0; a < DEPTH; a++) chk("final_mem", int'(mem[a]), int'(exp_mem[a]));
  endtask

  task automatic clean_img();
    for (int a = 0; a < DEPTH; a++) img[a] = cb[8'b10101100];
    for (int i = 0; i < 64; i++) stalls[i] = 0;
  endtask

  initial begin
    logic [12:0] cw;
    bit found;
    fork monitor(); join_none
    for (int d = 0; d < 256; d++) begin
      enc_d = 8'(d);
      #1 cb[d] = enc_cw;
    end
    @(posedge clk); #1 rst = 1'b0;
    chk_reset("reset");

    clean_img(); run_pass(0);
    clean_img(); img[2] ^= 13'h001; run_pass(0);
    clean_img(); img[1] ^= 13'h030; run_pass(0);
    clean_img(); img[3] ^= 13'h081; run_pass(0);
    clean_img(); stalls[1] = 5; run_pass(0);
    clean_img(); for (int a = 0; a < DEPTH; a++) img[a] ^= 13'h101; run_pass(0);
    clean_img(); for (int a = 0; a < DEPTH; a++) img[a] ^= 13'(1) << (3 * a); run_pass(0);

    // reset while the write to address 2 is still ungranted
    clean_img(); img[2] ^= 13'h001; stalls[3] = 3;
    load_and_start();
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      found = mem_req && mem_we && mem_addr == 2;
    end
    chk("rst_reached_wr", int'(found), 1);
    chk("pre_rst_corr", int'(corr_cnt), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_reset("midrst");
    unc_last = 0;
    stalls[3] = 0;
    run_pass(0);

    for (int it = 0; it < 16; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        cw = cb[$urandom_range(0, 255)];
        case ($urandom_range(0, 3))
          1: cw ^= 13'(1) << $urandom_range(0, 12);
          2: cw ^= 13'(3) << $urandom_range(0, 11);
          3: repeat (3) cw ^= 13'(1) << $urandom_range(0, 12);
          default: ;
        endcase
        img[a] = cw;
      end
      for (int i = 0; i < 64; i++)
        stalls[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_pass($urandom_range(0, 1) ? $urandom_range(2, 10) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fuec_scrubber_13_8.md
# fuec_scrubber_13_8

Background memory scrubber for arrays protected by the FUEC (13,8) code. On `start` it walks every address of a single-port, synchronous-read memory and runs each 13-bit codeword through one `fuec_decoder_13_8` instance. Correctable words are written back repaired; uncorrectable words are logged and never written. It shares the memory port with host traffic through a request/grant handshake.

## Interface
- `DEPTH`, 256: number of words scrubbed per pass (≥2).
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `CNT_W`, 16: width of the error counters.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  begin a pass; honoured only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a pass ends.
- `mem_req`  out  1  port request; held until granted.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  13  repaired codeword (`r_fix`).
- `mem_gnt`  in  1  access accepted this cycle when `mem_req & mem_gnt`.
- `mem_rdata`  in  13  read data, valid exactly one cycle after an accepted read.
- `corr_cnt`  out  CNT_W  corrected words this pass, saturating.
- `unc_cnt`  out  CNT_W  uncorrectable words this pass, saturating.
- `unc_addr`  out  ADDR_W  address of the most recent uncorrectable word.
- `unc_irq`  out  1  one-cycle pulse per uncorrectable word.

## Operation
- States: IDLE, RD, WT, CK, WR (plus RRD/RWT/RCK under the macro).
- IDLE: `start` clears `corr_cnt` and `unc_cnt` and sets `addr` to 0, then goes to RD. `unc_addr` keeps its value. A `start` in any other state is ignored.
- RD: `mem_req=1`, `mem_we=0`. On `mem_gnt` go to WT.
- WT: capture `mem_rdata` into `r_q`, go to CK.
- CK: the decoder sees `r_q`; its flags and `r_fix` are registered where used.
  - `no_error`: advance.
  - `corrected`: latch `r_fix` into `wdata_q`, increment `corr_cnt`, go to WR.
  - `uncorrectable`: set `unc_addr=addr`, increment `unc_cnt`, pulse `unc_irq`, advance. No write.
- WR: `mem_req=1`, `mem_we=1`, `mem_wdata=wdata_q`. On `mem_gnt`, advance.
- Advance: if `addr==DEPTH-1`, pulse `done` and go to IDLE. Otherwise `addr+1` and go to RD.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `mem_addr` is stable and `mem_req` is held for the whole RD/WR wait. Request parameters never change while a request is ungranted.

## Timing
- Reset values: `busy=0`, `done=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `corr_cnt=0`, `unc_cnt=0`, `unc_addr=0`, `unc_irq=0`. State returns to IDLE.
- Reset mid-pass: the next cycle is IDLE with `mem_req=0`. A write that was pending but ungranted is dropped. A write that was granted in the reset cycle counts as done by the memory.
- With `mem_gnt` always high:
  - A clean word takes 3 cycles (RD, WT, CK).
  - A corrected word takes 4 cycles (RD, WT, CK, WR).
- If `start` is sampled in cycle 0 and all words are clean, RD of address 0 is in cycle 1 and `done` pulses in cycle 3·DEPTH+1. `busy` falls in that same cycle.
- Each cycle of `mem_gnt=0` in RD or WR adds one cycle. A stall has no other effect.
- `unc_irq` and the counter updates appear the cycle after CK.

## Configuration
- `FUEC_SCRUB_RECHECK_EN` defined:
  - After a granted WR, the block re-reads the same address (RRD → RWT → RCK).
  - In RCK, `no_error` → advance.
  - Anything else → `unc_cnt++`, `unc_irq`, `unc_addr=addr`, advance. `corr_cnt` is not decremented.
  - A corrected word then costs 7 cycles.
- Undefined: WR advances directly. The RR* states and their logic are absent.

## Structure
- Package `fuec_13_8_pkg` holds:
  - `CW_W=13`, `DATA_W=8`, `PAR_W=5`.
  - The `scrub_state_t` enum, shared with future controllers for this code.
- The only sub-module is the existing `fuec_decoder_13_8`, instantiated once on `r_q`. The block does not need an encoder, because repaired words come from `r_fix`.

## Test plan
All scenarios use DEPTH=4, a behavioural 1-cycle-read memory, and data 8'b10101100 encoded by `fuec_encoder_13_8` in every word.
- Clean pass, `mem_gnt`=1 → `done` at cycle 13, no writes, `corr_cnt=0`, `unc_cnt=0`.
- Bit 0 of address 2 flipped → one write to address 2 with the clean codeword, `corr_cnt=1`, `done` at cycle 14.
- Bits 4 and 5 of address 1 flipped → address 1 restored, `corr_cnt=1`.
- Bits 0 and 7 of address 3 flipped → the bench checks the decoder flags:
  - If flagged uncorrectable: no write, `unc_cnt=1`, `unc_addr=3`, one `unc_irq` pulse.
  - Otherwise: a write to address 3 occurs and is counted per the flag.
- `mem_gnt` low for 5 cycles during RD of address 1 → `mem_addr` and `mem_req` stay stable, `done` is 5 cycles later, results are unchanged.
- `rst` asserted in WR of address 2 → IDLE next cycle, all outputs at reset values, no write issued. A new `start` then runs a full pass.
